// File: rtl/isp_1bit_bbox_detect.sv
// Bounding-box and foreground-count detector for the 1-bit morphology stream.
// Also re-emits the video as RGB565 with the previous frame's box outlined in red.
module isp_1bit_bbox_detect #(
    parameter int H_BITS     = 11,
    parameter int V_BITS     = 11,
    parameter int CNT_BITS   = 21,
    parameter int MIN_PIXELS = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                bin_wr_en,
    input  logic                bin_href,
    input  logic                bin_vsync,
    input  logic                img_1bit_in,
    output logic [H_BITS-1:0]   box_x_min,
    output logic [H_BITS-1:0]   box_x_max,
    output logic [V_BITS-1:0]   box_y_min,
    output logic [V_BITS-1:0]   box_y_max,
    output logic [CNT_BITS-1:0] box_pix_cnt,
    output logic                box_found,
    output logic                box_valid,
    output logic                out_wr_en,
    output logic                out_href,
    output logic                out_vsync,
    output logic [15:0]         out_rgb565
);

    localparam logic [CNT_BITS-1:0] MIN_CNT = CNT_BITS'(MIN_PIXELS);
    localparam logic [15:0] RGB_RED   = 16'hF800;
    localparam logic [15:0] RGB_WHITE = 16'hFFFF;

    logic                vsync_d, href_d;
    logic                vs_rise, hs_fall, fg_pix, armed;
    logic [H_BITS-1:0]   x_cnt, x_min, x_max;
    logic [V_BITS-1:0]   y_cnt, y_min, y_max;
    logic [CNT_BITS-1:0] pix_cnt;
    logic                on_col, on_row, outline;

    assign vs_rise = bin_vsync & ~vsync_d;
    assign hs_fall = ~bin_href & href_d;
    // A pixel coinciding with vs_rise belongs to neither frame.
    assign fg_pix  = bin_wr_en & img_1bit_in & ~vs_rise;

    // NOTE: all state uses non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
            x_cnt   <= '0;
            y_cnt   <= '0;
        end else begin
            vsync_d <= bin_vsync;
            href_d  <= bin_href;
            if (vs_rise || hs_fall)
                x_cnt <= '0;
            else if (bin_wr_en && x_cnt != '1)
                x_cnt <= x_cnt + 1'b1;
            if (vs_rise)
                y_cnt <= '0;
            else if (hs_fall && y_cnt != '1)
                y_cnt <= y_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x_min   <= '1;
            x_max   <= '0;
            y_min   <= '1;
            y_max   <= '0;
            pix_cnt <= '0;
        end else if (vs_rise) begin
            x_min   <= '1;
            x_max   <= '0;
            y_min   <= '1;
            y_max   <= '0;
            pix_cnt <= '0;
        end else if (fg_pix) begin
            if (x_cnt < x_min) x_min <= x_cnt;
            if (x_cnt > x_max) x_max <= x_cnt;
            if (y_cnt < y_min) y_min <= y_cnt;
            if (y_cnt > y_max) y_max <= y_cnt;
            if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
        end
    end

    // The first vs_rise after reset only arms; its partial frame is dropped.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            armed       <= 1'b0;
            box_valid   <= 1'b0;
            box_found   <= 1'b0;
            box_x_min   <= '0;
            box_x_max   <= '0;
            box_y_min   <= '0;
            box_y_max   <= '0;
            box_pix_cnt <= '0;
        end else begin
            box_valid <= vs_rise & armed;
            if (vs_rise) begin
                armed <= 1'b1;
                if (armed) begin
                    box_x_min   <= x_min;
                    box_x_max   <= x_max;
                    box_y_min   <= y_min;
                    box_y_max   <= y_max;
                    box_pix_cnt <= pix_cnt;
                    box_found   <= (pix_cnt >= MIN_CNT);
                end
            end
        end
    end

    always_comb begin
        on_col  = (x_cnt == box_x_min || x_cnt == box_x_max) &&
                  (y_cnt >= box_y_min && y_cnt <= box_y_max);
        on_row  = (y_cnt == box_y_min || y_cnt == box_y_max) &&
                  (x_cnt >= box_x_min && x_cnt <= box_x_max);
        outline = box_found & (on_col | on_row);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_wr_en  <= 1'b0;
            out_href   <= 1'b0;
            out_vsync  <= 1'b0;
            out_rgb565 <= '0;
        end else begin
            out_wr_en <= bin_wr_en;
            out_href  <= bin_href;
            out_vsync <= bin_vsync;
            if (!bin_wr_en)
                out_rgb565 <= '0;
            else if (outline)
                out_rgb565 <= RGB_RED;
            else
                out_rgb565 <= img_1bit_in ? RGB_WHITE : 16'h0000;
        end
    end

endmodule

// File: doc/isp_1bit_bbox_detect.md
# isp_1bit_bbox_detect

Sink for the 1-bit morphology video stream (binarize → erosion/dilation → this block). It measures the bounding box and pixel count of all foreground pixels (value 1) in each frame and reports them once per frame on the vsync rising edge. It also re-emits the video as RGB565, delayed one cycle, with the previous frame's box drawn as a red outline. Its outputs feed the tracking/overlay path ahead of the frame buffer writer.

## Interface
Parameters:
- H_BITS, 11, width of column counter and x outputs
- V_BITS, 11, width of row counter and y outputs
- CNT_BITS, 21, width of foreground pixel counter
- MIN_PIXELS, 16, minimum foreground count for box_found=1

Ports:
- sys_clk  in  1  pixel clock; reset sys_rst_n, asynchronous, active-low; clock sys_clk
- sys_rst_n  in  1  asynchronous active-low reset
- bin_wr_en  in  1  pixel valid
- bin_href  in  1  line active, high during line
- bin_vsync  in  1  frame sync, active-high pulse in vertical blanking
- img_1bit_in  in  1  pixel, 1 = foreground (white)
- box_x_min / box_x_max  out  H_BITS  latched box columns
- box_y_min / box_y_max  out  V_BITS  latched box rows
- box_pix_cnt  out  CNT_BITS  latched foreground count
- box_found  out  1  latched box_pix_cnt >= MIN_PIXELS
- box_valid  out  1  one-cycle pulse when box_* updated
- out_wr_en, out_href, out_vsync  out  1  inputs delayed 1 cycle
- out_rgb565  out  16  overlay pixel, aligned with out_wr_en

## Operation
- Edge detect: vsync_d, href_d registers. vs_rise = bin_vsync & ~vsync_d; hs_fall = ~bin_href & href_d.
- Column counter x: +1 on each bin_wr_en=1 cycle (after use); cleared on hs_fall and vs_rise; saturates at 2^H_BITS-1.
- Row counter y: +1 on hs_fall; cleared on vs_rise; saturates at 2^V_BITS-1.
- Accumulators, per pixel with bin_wr_en=1 and img_1bit_in=1: x_min=min(x_min,x), x_max=max(x_max,x), y_min/y_max likewise with y, cnt+1 saturating at 2^CNT_BITS-1.
- Accumulator clear value: x_min/y_min all ones, x_max/y_max/cnt zero.
- vs_rise: if armed, copy accumulators to box_* and set box_found; then clear accumulators and set armed=1. First vs_rise after reset only arms; the partial frame is never reported.
- Empty frame (cnt=0): box_* report the clear values (min all ones, max 0), box_found=0.
- vs_rise has priority. A pixel with bin_wr_en=1 in the vs_rise cycle is discarded and does not count toward either frame.
- Overlay, registered, using latched box_*:
  - Outline pixel: box_found=1 and (x==box_x_min or x==box_x_max) with y in [box_y_min,box_y_max], or (y==box_y_min or y==box_y_max) with x in [box_x_min,box_x_max]. Outline pixel → 16'hF800.
  - Otherwise img_1bit_in ? 16'hFFFF : 16'h0000.
  - out_rgb565 = 0 when the delayed wr_en = 0.

## Timing
- Reset values: all box_* = 0; box_found, box_valid, armed = 0; out_* = 0. Accumulators take clear values; x, y = 0.
- Results latency: box_* and box_valid are updated at the clock edge that samples vs_rise. box_valid is high for exactly that following cycle. box_* hold until the next armed vs_rise.
- Video latency: out_wr_en/out_href/out_vsync/out_rgb565 = inputs + 1 cycle, no gaps or reordering.
- Back-to-back vsync pulses with no lines: each armed vs_rise reports an empty frame.
- Reset mid-frame: everything returns to reset values. The next vs_rise only re-arms.
- x, y outputs of the counters never wrap. Saturated values are used as-is in comparisons.

## Test plan
- After reset, 8x6 frame all zero with vsync before and after → first vs_rise gives no box_valid. Second gives box_valid=1 for one cycle, box_pix_cnt=0, box_found=0, box_x_min=2047, box_x_max=0.
- MIN_PIXELS=4, 8x6 frame with 1s at (x,y) = (2,1),(5,1),(2,4),(5,4),(3,2) → box_x_min=2, box_x_max=5, box_y_min=1, box_y_max=4, box_pix_cnt=5, box_found=1.
- Same frame with MIN_PIXELS=16 → same box_*, box_found=0. Next frame's out_rgb565 contains no 16'hF800.
- Frame after the box above, all-zero input → out_rgb565=16'hF800 exactly on the perimeter (x=2..5 on rows 1 and 4; columns 2 and 5 on rows 1..4), 16'h0000 elsewhere. Each output appears one cycle after its pixel.
- Foreground pixel asserted with bin_wr_en in the vs_rise cycle → excluded from both frames' box_pix_cnt.
- Assert sys_rst_n low mid-frame for 3 cycles → all outputs 0 immediately. First subsequent vs_rise gives no box_valid; the following one reports correctly.
